bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 18 +
 rtl/bus_arbiter_if.sv | 62 ++++++
 rtl/arb_starve_cnt.sv | 45 ++++
 rtl/bus_arbiter.sv | 132 +++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared constants for the three-port memory arbiter: port indices,
// FSM state encoding and the default starvation threshold.
package bus_arbiter_pkg;

    localparam int unsigned PORT_I  = 0;
    localparam int unsigned PORT_D  = 1;
    localparam int unsigned PORT_X  = 2;
    localparam int unsigned N_PORTS = 3;

    localparam int unsigned DW    = 32;
    localparam int unsigned CNT_W = 3;

    localparam int unsigned STARVE_MAX_DEF = 4;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

endpackage

// File: rtl/bus_arbiter_if.sv
// Requester and memory signals of the arbiter, grouped into one bundle.
// slave = arbiter side, master = requesters plus RAM.
interface bus_arbiter_if
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned AW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_valid;
    logic [DW-1:0] i_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_valid;
    logic [DW-1:0] d_rdata;

    logic          x_req;
    logic          x_lock;
    logic          x_we;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_wdata;
    logic          x_gnt;
    logic          x_valid;
    logic [DW-1:0] x_rdata;

    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_valid, i_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_valid, d_rdata,
        input  x_req, x_lock, x_we, x_addr, x_wdata,
        output x_gnt, x_valid, x_rdata,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_valid, i_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_valid, d_rdata,
        output x_req, x_lock, x_we, x_addr, x_wdata,
        input  x_gnt, x_valid, x_rdata,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata,
        input  busy
    );

endinterface

// File: rtl/arb_starve_cnt.sv
// Per-port saturating starvation counter. Counts cycles a request waits
// ungranted; at_max_o flags that the port has waited long enough to jump
// ahead of base priority. inc_en_i low freezes the count (loader lock).
module arb_starve_cnt
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    input  logic gnt_i,
    input  logic inc_en_i,
    output logic at_max_o
);
    localparam logic [CNT_W-1:0] CNT_SAT = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear when idle or served, otherwise count up and stick at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (!req_i || gnt_i) begin
            cnt_d = '0;
        end else if (inc_en_i && (cnt_q != CNT_SAT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A port that already reached the threshold stays promoted while it keeps
    // waiting, so a second promoted port is still served after the first.
    assign at_max_o = (cnt_q >= CNT_MAX);

endmodule

// File: rtl/bus_arbiter.sv
// Three-port arbiter in front of a single-port synchronous RAM.
// Base priority data > fetch > loader; starved ports are promoted
// (loader > fetch > data among themselves); the loader can lock the bus
// for a burst.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
    parameter int unsigned AW         = 32
) (
    input  logic         clk,
    input  logic         rst,
    bus_arbiter_if.slave bus
);
    logic [N_PORTS-1:0]         req;
    logic [N_PORTS-1:0]         wr;
    logic [N_PORTS-1:0]         gnt;
    logic [N_PORTS-1:0]         at_max;
    logic [N_PORTS-1:0]         promo;
    logic                       lock_hold;
    logic [0:0]                 state_q;
    logic [0:0]                 state_d;
    logic [N_PORTS-1:0]         pend_q;
    logic [N_PORTS-1:0]         pend_d;
    logic [N_PORTS-1:0]         valid;
    logic [N_PORTS-1:0][DW-1:0] rdata_q;
    logic [AW-1:0]              addr_mux;
    logic                       we_mux;
    logic [DW-1:0]              wdata_mux;

    // Bit positions follow PORT_I=0, PORT_D=1, PORT_X=2.
    assign req       = {bus.x_req, bus.d_req, bus.i_req};
    assign wr        = {bus.x_we, bus.d_we, 1'b0};
    assign promo     = req & at_max;
    // Lock only persists while the loader keeps both req and lock up;
    // the cycle either drops arbitrates normally.
    assign lock_hold = (state_q == ST_LOCKED) && bus.x_req && bus.x_lock;

    for (genvar p = 0; p < N_PORTS; p++) begin : g_cnt
        arb_starve_cnt #(
            .STARVE_MAX(STARVE_MAX)
        ) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .req_i    (req[p]),
            .gnt_i    (gnt[p]),
            .inc_en_i (!lock_hold),
            .at_max_o (at_max[p])
        );
    end

    // One-hot grant: lock, then promoted ports, then base priority.
    always_comb begin
        gnt = '0;
        if (!rst) begin
            gnt = '0;
        end else if (lock_hold) begin
            gnt[PORT_X] = 1'b1;
        end else if (promo[PORT_X]) begin
            gnt[PORT_X] = 1'b1;
        end else if (promo[PORT_I]) begin
            gnt[PORT_I] = 1'b1;
        end else if (promo[PORT_D]) begin
            gnt[PORT_D] = 1'b1;
        end else if (req[PORT_D]) begin
            gnt[PORT_D] = 1'b1;
        end else if (req[PORT_I]) begin
            gnt[PORT_I] = 1'b1;
        end else if (req[PORT_X]) begin
            gnt[PORT_X] = 1'b1;
        end
    end

    // Route the granted port onto the RAM; idle bus drives zeros.
    always_comb begin
        addr_mux  = '0;
        we_mux    = 1'b0;
        wdata_mux = '0;
        if (gnt[PORT_D]) begin
            addr_mux  = bus.d_addr;
            we_mux    = bus.d_we;
            wdata_mux = bus.d_wdata;
        end else if (gnt[PORT_X]) begin
            addr_mux  = bus.x_addr;
            we_mux    = bus.x_we;
            wdata_mux = bus.x_wdata;
        end else if (gnt[PORT_I]) begin
            addr_mux  = bus.i_addr;
        end
    end

    assign state_d = (gnt[PORT_X] && bus.x_lock) ? ST_LOCKED : ST_IDLE;
    assign pend_d  = gnt & ~wr;

    // FSM, read-pending flags and held read data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            for (int p = 0; p < N_PORTS; p++) begin
                if (pend_q[p]) begin
                    rdata_q[p] <= bus.mem_rdata;
                end
            end
        end
    end

    // Masking with rst kills a read that was in flight when reset arrived.
    assign valid = pend_q & {N_PORTS{rst}};

    assign bus.mem_addr  = addr_mux;
    assign bus.mem_we    = we_mux;
    assign bus.mem_wdata = wdata_mux;

    assign bus.i_gnt   = gnt[PORT_I];
    assign bus.d_gnt   = gnt[PORT_D];
    assign bus.x_gnt   = gnt[PORT_X];
    assign bus.i_valid = valid[PORT_I];
    assign bus.d_valid = valid[PORT_D];
    assign bus.x_valid = valid[PORT_X];

    assign bus.i_rdata = valid[PORT_I] ? bus.mem_rdata : (rst ? rdata_q[PORT_I] : '0);
    assign bus.d_rdata = valid[PORT_D] ? bus.mem_rdata : (rst ? rdata_q[PORT_D] : '0);
    assign bus.x_rdata = valid[PORT_X] ? bus.mem_rdata : (rst ? rdata_q[PORT_X] : '0);

    assign bus.busy = rst && (state_q == ST_LOCKED);

endmodule
